// File: rtl/jpeg_idct_sched_pkg.sv
// Shared definitions for the JPEG IDCT block scheduler: FSM encoding and
// default sizing of the in-flight window and downstream credit pool.
package jpeg_idct_sched_pkg;

  localparam int MAX_INFLIGHT_DEF = 8;
  localparam int CREDITS_DEF      = 4;
  // The block-ID FIFO holds one entry per block admitted to the IDCT.
  localparam int ID_FIFO_DEPTH    = MAX_INFLIGHT_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_BLOCK = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/jpeg_idct_sched_if.sv
// Coefficient handshake, IDCT completion and downstream credit signals
// between the entropy decoder / IDCT side and the scheduler.
interface jpeg_idct_sched_if;
  logic       inport_valid_i;
  logic       inport_eob_i;
  logic       inport_accept_o;
  logic       idct_valid_o;
  logic       idct_accept_i;
  logic       done_valid_i;
  logic [5:0] done_idx_i;
  logic       credit_i;

  modport master (
    output inport_valid_i, inport_eob_i, idct_accept_i,
           done_valid_i, done_idx_i, credit_i,
    input  inport_accept_o, idct_valid_o
  );

  modport slave (
    input  inport_valid_i, inport_eob_i, idct_accept_i,
           done_valid_i, done_idx_i, credit_i,
    output inport_accept_o, idct_valid_o
  );
endinterface

// File: rtl/jpeg_idct_sched_sat_cnt.sv
// Up/down counter clamped to 0..MAX; flags an increment attempted at MAX or a
// decrement attempted at 0 (a simultaneous inc+dec is a no-op and never flags).
module jpeg_idct_sat_cnt #(
  parameter int W       = 4,
  parameter int MAX     = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf,
  output logic         unf
);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] RST_V = W'(RST_VAL);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] count_r;
  logic         at_max_s;
  logic         at_zero_s;

  assign at_max_s  = (count_r == MAX_V);
  assign at_zero_s = (count_r == {W{1'b0}});

  // Count register: clear reloads the start value and overrides any step
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= RST_V;
    end else if (inc && !dec && !at_max_s) begin
      count_r <= count_r + ONE_V;
    end else if (dec && !inc && !at_zero_s) begin
      count_r <= count_r - ONE_V;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign ovf   = !clr && inc && !dec && at_max_s;
  assign unf   = !clr && dec && !inc && at_zero_s;
endmodule

// File: rtl/jpeg_idct_sched.sv
// Admission gate between the entropy decoder and the IDCT: limits blocks in
// flight, honours downstream credits, and tracks image start/end/drain.
module jpeg_idct_sched
  import jpeg_idct_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CREDITS      = CREDITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    img_start_i,
  input  logic                    img_end_i,
  jpeg_idct_sched_if.slave        bus,
  output logic [3:0]              inflight_o,
  output logic [2:0]              credits_o,
  output logic                    busy_o,
  output logic                    drained_o,
  output logic                    err_o
);
  state_e     state_r;
  state_e     state_nxt_s;
  logic       pend_r;
  logic       pend_nxt_s;
  logic       err_r;
  logic       gate_s;
  logic       hs_s;
  logic       eob_hs_s;
  logic       done_s;
  logic       idle_viol_s;
  logic [3:0] inflight_s;
  logic [2:0] credits_s;
  logic       inf_ovf_s;
  logic       inf_unf_s;
  logic       cr_ovf_s;
  logic       cr_unf_s;

  // Gate: always open mid-block so a started block is never split
  always_comb begin
    gate_s = 1'b0;
    if (rst_i || img_start_i) begin
      gate_s = 1'b0;
    end else begin
      case (state_r)
        ST_BLOCK: gate_s = 1'b1;
        ST_OPEN:  gate_s = (inflight_s < 4'(MAX_INFLIGHT)) && (credits_s != 3'd0);
        default:  gate_s = 1'b0;
      endcase
    end
  end

  assign bus.idct_valid_o    = bus.inport_valid_i & gate_s;
  assign bus.inport_accept_o = bus.idct_accept_i & gate_s;
  assign hs_s        = bus.inport_valid_i & bus.inport_accept_o;
  assign eob_hs_s    = hs_s & bus.inport_eob_i;
  assign done_s      = bus.done_valid_i && (bus.done_idx_i == 6'd63);
  assign idle_viol_s = (state_r == ST_IDLE) && bus.inport_valid_i && bus.idct_accept_i;

  jpeg_idct_sat_cnt #(.W(4), .MAX(MAX_INFLIGHT), .RST_VAL(0)) u_inflight (
    .clk(clk_i), .rst(rst_i), .clr(img_start_i),
    .inc(eob_hs_s), .dec(done_s),
    .count(inflight_s), .ovf(inf_ovf_s), .unf(inf_unf_s)
  );

  jpeg_idct_sat_cnt #(.W(3), .MAX(CREDITS), .RST_VAL(CREDITS)) u_credits (
    .clk(clk_i), .rst(rst_i), .clr(img_start_i),
    .inc(bus.credit_i), .dec(eob_hs_s),
    .count(credits_s), .ovf(cr_ovf_s), .unf(cr_unf_s)
  );

  // Next state; an img_end arriving mid-block is held until that block's eob
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    if (img_start_i) begin
      state_nxt_s = ST_OPEN;
      pend_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_OPEN: begin
          if (img_end_i) begin
            state_nxt_s = ST_DRAIN;
          end else if (hs_s && !bus.inport_eob_i) begin
            state_nxt_s = ST_BLOCK;
          end else begin
            state_nxt_s = ST_OPEN;
          end
        end
        ST_BLOCK: begin
          if (eob_hs_s) begin
            state_nxt_s = (img_end_i || pend_r) ? ST_DRAIN : ST_OPEN;
            pend_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = ST_BLOCK;
            pend_nxt_s  = pend_r | img_end_i;
          end
        end
        ST_DRAIN: begin
          if (inflight_s == 4'd0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          pend_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State and pending-end registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

  // Sticky protocol error; a new image clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (img_start_i) begin
      err_r <= 1'b0;
    end else if (inf_ovf_s || inf_unf_s || cr_ovf_s || cr_unf_s || idle_viol_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign inflight_o = inflight_s;
  assign credits_o  = credits_s;
  assign busy_o     = (state_r != ST_IDLE);
  assign drained_o  = !rst_i && (state_r == ST_DRAIN) && (inflight_s == 4'd0);
  assign err_o      = err_r;
endmodule

// File: tb/tb_jpeg_idct_sched.sv
// Self-checking bench for jpeg_idct_sched: a per-cycle vector table run
// through an expected-result queue, plus hand-written multi-cycle sequences.
module tb_jpeg_idct_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       img_start;
  logic       img_end;
  logic [3:0] inflight;
  logic [2:0] credits;
  logic       busy;
  logic       drained;
  logic       err;
  int         n_vec = 0;
  int         n_err = 0;

  jpeg_idct_sched_if bus ();

  jpeg_idct_sched dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start), .img_end_i(img_end),
    .bus(bus), .inflight_o(inflight), .credits_o(credits),
    .busy_o(busy), .drained_o(drained), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, en, v, e, a, dv;
    logic [5:0] di;
    logic       cr;
    logic       exp_acc;
    logic [3:0] exp_inf;
    logic [2:0] exp_cr;
    logic       exp_busy, exp_err, exp_drn;
  } vec_t;

  vec_t tbl [16];
  vec_t sbq [$];

  function automatic vec_t mk(input logic st, en, v, e, a, dv, input logic [5:0] di,
                              input logic cr, acc, input logic [3:0] inf,
                              input logic [2:0] crd, input logic bsy, er, drn);
    vec_t r;
    r.st = st; r.en = en; r.v = v; r.e = e; r.a = a; r.dv = dv; r.di = di; r.cr = cr;
    r.exp_acc = acc; r.exp_inf = inf; r.exp_cr = crd;
    r.exp_busy = bsy; r.exp_err = er; r.exp_drn = drn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, en, v, e, a, dv, input logic [5:0] di, input logic cr);
    img_start = st; img_end = en;
    bus.inport_valid_i = v; bus.inport_eob_i = e; bus.idct_accept_i = a;
    bus.done_valid_i = dv; bus.done_idx_i = di; bus.credit_i = cr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("rst_accept", 32'(bus.inport_accept_o), 32'd0);
    chk("rst_idct_valid", 32'(bus.idct_valid_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    #1;
  endtask

  task automatic start_img();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
  endtask

  // n single-coefficient blocks; optional credit return alongside each eob
  task automatic eob_blocks(input int n, input logic with_credit);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, with_credit);
      tick();
    end
  endtask

  initial begin
    vec_t ev;
    int   ndrn;

    //            st    en    v     e     a     dv    di     cr    acc   inf   cr    busy  err   drn
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 4'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 4'd2, 3'd2, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63, 1'b0, 1'b1, 4'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd62, 1'b1, 1'b0, 4'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd63, 1'b0, 1'b1, 4'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0, 4'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 4'd0, 3'd3, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 4'd0, 3'd4, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 4'd0, 3'd4, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b1, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 3'd4, 1'b0, 1'b1, 1'b0);

    do_reset();
    chk("reset_inflight", 32'(inflight), 32'd0);
    chk("reset_credits", 32'(credits), 32'd4);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_drained", 32'(drained), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].st, tbl[i].en, tbl[i].v, tbl[i].e, tbl[i].a, tbl[i].dv, tbl[i].di, tbl[i].cr);
      sbq.push_back(tbl[i]);
      #1;
      chk($sformatf("v%0d_accept", i), 32'(bus.inport_accept_o), 32'(tbl[i].exp_acc));
      tick();
      ev = sbq.pop_front();
      chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(ev.exp_inf));
      chk($sformatf("v%0d_credits", i), 32'(credits), 32'(ev.exp_cr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(ev.exp_busy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(ev.exp_err));
      chk($sformatf("v%0d_drained", i), 32'(drained), 32'(ev.exp_drn));
    end

    // Reset wins over a coincident img_start
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    rst = 1'b0;
    idle_cycle();
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    chk("rst_over_start_err", 32'(err), 32'd0);

    // One 64-coefficient block, then its 64 IDCT output samples
    do_reset();
    start_img();
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i == 63) ? 1'b1 : 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      tick();
    end
    chk("blk64_inflight", 32'(inflight), 32'd1);
    chk("blk64_credits", 32'(credits), 32'd3);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'(i), 1'b0);
      tick();
      if (i == 62) chk("blk64_inflight_idx62", 32'(inflight), 32'd1);
    end
    chk("blk64_inflight_done", 32'(inflight), 32'd0);
    chk("blk64_credits_done", 32'(credits), 32'd3);

    // In-flight limit: eight blocks with credits returned as they are consumed
    start_img();
    eob_blocks(8, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("max_inflight_accept", 32'(bus.inport_accept_o), 32'd0);
    chk("max_inflight_idct_valid", 32'(bus.idct_valid_o), 32'd0);
    chk("max_inflight_count", 32'(inflight), 32'd8);
    chk("max_inflight_credits", 32'(credits), 32'd4);
    tick();
    chk("max_inflight_hold", 32'(inflight), 32'd8);
    chk("max_inflight_err", 32'(err), 32'd0);

    // Credit exhaustion and reopening one cycle after a credit pulse
    start_img();
    eob_blocks(4, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("no_credit_accept", 32'(bus.inport_accept_o), 32'd0);
    chk("no_credit_credits", 32'(credits), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    #1;
    chk("credit_pulse_cycle_accept", 32'(bus.inport_accept_o), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("credit_reopen_accept", 32'(bus.inport_accept_o), 32'd1);
    chk("credit_reopen_idct_valid", 32'(bus.idct_valid_o), 32'd1);
    chk("credit_reopen_credits", 32'(credits), 32'd1);
    tick();

    // img_end mid-block: drain happens only after the eob and both completions
    start_img();
    eob_blocks(1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("end_midblock_still_open", 32'(bus.inport_accept_o), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    chk("drain_inflight", 32'(inflight), 32'd2);
    chk("drain_no_pulse_yet", 32'(drained), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("drain_gate_closed", 32'(bus.inport_accept_o), 32'd0);
    ndrn = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k < 2) ? 1'b1 : 1'b0, 6'd63, 1'b0);
      tick();
      if (drained) ndrn++;
      if (k == 0) chk("drain_k0_drained", 32'(drained), 32'd0);
      if (k == 1) chk("drain_k1_drained", 32'(drained), 32'd1);
      if (k == 1) chk("drain_k1_inflight", 32'(inflight), 32'd0);
    end
    chk("drain_pulse_count", 32'(ndrn), 32'd1);
    chk("drain_end_busy", 32'(busy), 32'd0);

    // img_start mid-block with three blocks in flight and the error set
    start_img();
    eob_blocks(3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
      tick();
    end
    chk("restart_pre_err", 32'(err), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    chk("restart_pre_inflight", 32'(inflight), 32'd3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    #1;
    chk("restart_gate_closed", 32'(bus.inport_accept_o), 32'd0);
    tick();
    chk("restart_inflight", 32'(inflight), 32'd0);
    chk("restart_credits", 32'(credits), 32'd4);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("restart_open_end_drained", 32'(drained), 32'd1);
    idle_cycle();
    chk("restart_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jpeg_idct_sched.md
JPEG_IDCT_SCHED -- requirements
Module: jpeg_idct_sched

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8: maximum blocks admitted to the IDCT but not yet fully output; equals the block-ID FIFO depth.
REQ-002 Parameter CREDITS, default 4: downstream output-buffer block slots.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 img_start_i  in  1  pulse, new image; flushes scheduler state.
REQ-006 img_end_i  in  1  pulse, last block of image has been presented.
REQ-007 inport_valid_i  in  1  coefficient valid from the entropy decoder.
REQ-008 inport_eob_i  in  1  last coefficient of a block, qualified by inport_valid_i.
REQ-009 inport_accept_o  out  1  coefficient accepted upstream.
REQ-010 idct_valid_o  out  1  gated valid to the IDCT input.
REQ-011 idct_accept_i  in  1  IDCT input accept.
REQ-012 done_valid_i  in  1  IDCT output sample valid.
REQ-013 done_idx_i  in  6  IDCT output sample index.
REQ-014 credit_i  in  1  pulse, downstream freed one block slot.
REQ-015 inflight_o  out  4  blocks in flight.
REQ-016 credits_o  out  3  credits available.
REQ-017 busy_o  out  1  state is not IDLE.
REQ-018 drained_o  out  1  one-cycle pulse, image fully drained.
REQ-019 err_o  out  1  sticky protocol error.

Function
REQ-020 States: IDLE, OPEN (between blocks), BLOCK (mid-block), DRAIN.
REQ-021 Gate is open in BLOCK; in OPEN it is open only if inflight < MAX_INFLIGHT and credits > 0; closed in IDLE and DRAIN.
REQ-022 idct_valid_o = inport_valid_i AND gate; inport_accept_o = idct_accept_i AND gate; both combinational, zero latency.
REQ-023 A handshake is inport_valid_i AND inport_accept_o.
REQ-024 IDLE -> OPEN on img_start_i.
REQ-025 OPEN -> BLOCK on a handshake without eob; a handshake with eob (single-coefficient block) stays in OPEN.
REQ-026 BLOCK -> OPEN on a handshake with eob.
REQ-027 An eob handshake increments inflight and decrements credits in that cycle.
REQ-028 done_valid_i with done_idx_i == 63 decrements inflight.
REQ-029 credit_i increments credits.
REQ-030 Simultaneous increment and decrement of the same counter leaves it unchanged.
REQ-031 img_end_i in OPEN -> DRAIN; in BLOCK, it is latched and DRAIN is entered after the eob handshake.
REQ-032 DRAIN -> IDLE when inflight == 0, with drained_o asserted for that one cycle.
REQ-033 img_start_i in any state: inflight := 0, credits := CREDITS, pending img_end cleared, next state OPEN; gate is closed that cycle.
REQ-034 err_o is set on any of: inflight underflow (completion at 0); credits over CREDITS; handshake-eligible valid in IDLE; counter saturation attempt.
REQ-035 Counters saturate instead of wrapping: inflight in 0..MAX_INFLIGHT, credits in 0..CREDITS.
REQ-036 err_o is cleared only by reset or img_start_i.

Reset
REQ-037 On rst_i: state IDLE, inflight_o 0, credits_o CREDITS, busy_o 0, drained_o 0, err_o 0, pending img_end 0.
REQ-038 During reset, idct_valid_o and inport_accept_o are 0.
REQ-039 Reset has priority over img_start_i.

Structure
REQ-040 State encoding and the default MAX_INFLIGHT/CREDITS values live in the shared jpeg_idct package, also used by the ID FIFO depth.
REQ-041 There is a single sub-module, jpeg_idct_sat_cnt: an up/down saturating counter with overflow/underflow flags, instantiated twice.

Verification
REQ-042 Reset, img_start, one 64-coefficient block, then 64 done samples idx 0..63: inflight goes 0 -> 1 -> 0 and credits 4 -> 3.
REQ-043 Eight eob-only blocks with no completions and credits held: the 9th valid sees inport_accept_o=0 and inflight_o=8.
REQ-044 Credits exhausted after 4 blocks: gate closes; one credit_i pulse reopens the gate on the next cycle.
REQ-045 Completion (idx 63) coincident with an eob handshake: inflight is unchanged.
REQ-046 img_end mid-block, then eob, then 2 pending blocks complete: drained_o pulses exactly once, in the cycle inflight reaches 0, then IDLE.
REQ-047 img_start mid-block with inflight=3 and err set: next cycle inflight=0, credits=4, err=0, state OPEN.
